bram_readback_ctrl: RTL and testbench

Parametrised read-back controller between the address generators and the result BRAM banks. In normal mode it registers each bank's write enable and address from the address generators to the BRAM ports. In read-back mode it blocks all BRAM writes and drives one bank's contents to the display path. The read-back address comes either from the switches (manual) or from an auto-scan counter. Mode entry waits until any in-flight generator sequence has finished.

---
 rtl/bram_readback_ctrl.sv | 146 ++++++++++++++
 tb/tb_bram_readback_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_ctrl.sv
// Read-back controller between the address generators and the result BRAM banks.
// Normal mode registers generator traffic to the BRAMs; read-back mode blocks writes and streams one bank out.
module bram_readback_ctrl #(
    parameter int unsigned NUM_BANK = 3,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DWELL    = 4,
    parameter int unsigned RD_LAT   = 1,
    localparam int unsigned BANK_W  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BANK-1:0]          gen_wea,
    input  logic [NUM_BANK*ADDR_W-1:0]   gen_addr,
    input  logic                         gen_busy,
    input  logic                         rb_req,
    input  logic                         rb_auto,
    input  logic [BANK_W-1:0]            rb_bank,
    input  logic [ADDR_W-1:0]            switch,
    input  logic [NUM_BANK*DATA_W-1:0]   bram_dout,
    output logic [NUM_BANK-1:0]          bram_wea,
    output logic [NUM_BANK*ADDR_W-1:0]   bram_addr,
    output logic                         rb_active,
    output logic [ADDR_W-1:0]            rb_addr,
    output logic [DATA_W-1:0]            rb_data,
    output logic                         rb_valid
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] StNormal   = 2'd0;
    localparam logic [1:0] StDrain    = 2'd1;
    localparam logic [1:0] StReadback = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [NUM_BANK-1:0]         bram_wea_q, bram_wea_d;
    logic [NUM_BANK*ADDR_W-1:0]  bram_addr_q, bram_addr_d;
    logic                        rb_active_q, rb_active_d;
    logic [ADDR_W-1:0]           rb_addr_q, rb_addr_d;
    logic [DATA_W-1:0]           rb_data_q, rb_data_d;
    logic                        rb_valid_q, rb_valid_d;
    logic [ADDR_W-1:0]           scan_q, scan_d;
    logic [DW_W-1:0]             dwell_q, dwell_d;
    logic                        rb_auto_q;
    logic [BANK_W-1:0]           rb_bank_q;
    logic [RD_LAT:0]             pipe_vld_q, pipe_vld_d;
    logic [RD_LAT:0][BANK_W-1:0] pipe_bank_q, pipe_bank_d;

    logic              in_rb, entering, restart, rd_event;
    logic [ADDR_W-1:0] scan_cur, rb_addr_next;
    logic [DW_W-1:0]   dwell_cur;
    logic [BANK_W-1:0] bank_sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StNormal:   if (rb_req) state_d = gen_busy ? StDrain : StReadback;
            StDrain: begin
                if (!rb_req)        state_d = StNormal;
                else if (!gen_busy) state_d = StReadback;
            end
            StReadback: if (!rb_req) state_d = StNormal;
            default:    state_d = StNormal;
        endcase
    end

    // Outputs are decoded from the next state so mode changes land on the same edge as rb_active.
    always_comb begin
        in_rb        = (state_d == StReadback);
        entering     = in_rb && (state_q != StReadback);
        restart      = entering || ((state_q == StReadback) && rb_auto && !rb_auto_q);
        scan_cur     = restart ? '0 : scan_q;
        dwell_cur    = restart ? '0 : dwell_q;
        rb_addr_next = rb_auto ? scan_cur : switch;
        bank_sel     = (32'(rb_bank) < NUM_BANK) ? rb_bank : '0;
        rd_event     = in_rb && (entering || (rb_addr_next != rb_addr_q) || (rb_bank != rb_bank_q));

        bram_wea_d  = gen_wea;
        bram_addr_d = gen_addr;
        rb_active_d = in_rb;
        rb_addr_d   = rb_addr_q;
        scan_d      = scan_q;
        dwell_d     = dwell_q;
        pipe_vld_d  = '0;
        pipe_bank_d = pipe_bank_q;

        if (in_rb) begin
            bram_wea_d  = '0;
            bram_addr_d = {NUM_BANK{rb_addr_next}};
            rb_addr_d   = rb_addr_next;
            if (dwell_cur == DW_W'(DWELL - 1)) begin
                dwell_d = '0;
                scan_d  = scan_cur + ADDR_W'(1);
            end else begin
                dwell_d = dwell_cur + DW_W'(1);
                scan_d  = scan_cur;
            end
            pipe_vld_d  = {pipe_vld_q[RD_LAT-1:0], rd_event};
            pipe_bank_d = {pipe_bank_q[RD_LAT-1:0], bank_sel};
        end

        rb_valid_d = in_rb && pipe_vld_q[RD_LAT];
        rb_data_d  = rb_valid_d ? bram_dout[32'(pipe_bank_q[RD_LAT]) * DATA_W +: DATA_W]
                                : rb_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StNormal;
            bram_wea_q  <= '0;
            bram_addr_q <= '0;
            rb_active_q <= 1'b0;
            rb_addr_q   <= '0;
            rb_data_q   <= '0;
            rb_valid_q  <= 1'b0;
            scan_q      <= '0;
            dwell_q     <= '0;
            rb_auto_q   <= 1'b0;
            rb_bank_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_bank_q <= '0;
        end else begin
            state_q     <= state_d;
            bram_wea_q  <= bram_wea_d;
            bram_addr_q <= bram_addr_d;
            rb_active_q <= rb_active_d;
            rb_addr_q   <= rb_addr_d;
            rb_data_q   <= rb_data_d;
            rb_valid_q  <= rb_valid_d;
            scan_q      <= scan_d;
            dwell_q     <= dwell_d;
            rb_auto_q   <= rb_auto;
            rb_bank_q   <= rb_bank;
            pipe_vld_q  <= pipe_vld_d;
            pipe_bank_q <= pipe_bank_d;
        end
    end

    assign bram_wea  = bram_wea_q;
    assign bram_addr = bram_addr_q;
    assign rb_active = rb_active_q;
    assign rb_addr   = rb_addr_q;
    assign rb_data   = rb_data_q;
    assign rb_valid  = rb_valid_q;

endmodule

// File: tb/tb_bram_readback_ctrl.sv
// Bench for bram_readback_ctrl: directed vectors, an event-queue reference model checked every cycle,
// and a read-only BRAM model with one cycle of read latency.
module tb_bram_readback_ctrl;

    localparam int NB    = 3;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DWELL = 4;
    localparam int RDL   = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NB-1:0]    gen_wea = '0;
    logic [NB*AW-1:0] gen_addr = '0;
    logic             gen_busy = 1'b0;
    logic             rb_req = 1'b0;
    logic             rb_auto = 1'b0;
    logic [1:0]       rb_bank = '0;
    logic [AW-1:0]    sw = '0;
    logic [NB*DW-1:0] bram_dout;
    logic [NB-1:0]    bram_wea;
    logic [NB*AW-1:0] bram_addr;
    logic             rb_active;
    logic [AW-1:0]    rb_addr;
    logic [DW-1:0]    rb_data;
    logic             rb_valid;

    always #5 clk = ~clk;

    bram_readback_ctrl #(
        .NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gen_wea(gen_wea), .gen_addr(gen_addr), .gen_busy(gen_busy),
        .rb_req(rb_req), .rb_auto(rb_auto), .rb_bank(rb_bank), .switch(sw), .bram_dout(bram_dout),
        .bram_wea(bram_wea), .bram_addr(bram_addr), .rb_active(rb_active), .rb_addr(rb_addr),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    // Read-only BRAM model: contents are a per-bank ramp, registered read.
    logic [DW-1:0] mem [NB][1<<AW];
    logic [DW-1:0] dout_q [NB];
    always @(posedge clk)
        for (int k = 0; k < NB; k++) dout_q[k] <= mem[k][bram_addr[k*AW +: AW]];
    assign bram_dout = {dout_q[2], dout_q[1], dout_q[0]};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode rules, scan address from elapsed cycles, read events as a timed queue.
    typedef struct {int due; int bank; int addr;} ev_t;
    ev_t evq[$];
    int             m_mode, cyc, t0, nxt, a, b;
    logic           entering, ev;
    logic [NB-1:0]  m_wea;
    logic [NB*AW-1:0] m_addr;
    logic           m_active, m_valid, prev_auto;
    logic [AW-1:0]  m_rbaddr;
    logic [DW-1:0]  m_data;
    logic [1:0]     prev_bank;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; cyc = 0; t0 = 0;
            m_wea = '0; m_addr = '0; m_active = 0; m_valid = 0; m_rbaddr = '0; m_data = '0;
            prev_auto = 0; prev_bank = '0;
            evq.delete();
        end else begin
            case (m_mode)
                0:       nxt = rb_req ? (gen_busy ? 1 : 2) : 0;
                1:       nxt = !rb_req ? 0 : (gen_busy ? 1 : 2);
                default: nxt = rb_req ? 2 : 0;
            endcase
            if (nxt == 2) begin
                entering = (m_mode != 2);
                if (entering || (rb_auto && !prev_auto)) t0 = cyc;
                a  = rb_auto ? ((cyc - t0) / DWELL) % (1 << AW) : int'(sw);
                b  = (int'(rb_bank) < NB) ? int'(rb_bank) : 0;
                ev = entering || (a != int'(m_rbaddr)) || (rb_bank != prev_bank);
                m_valid = 0;
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    m_data  = mem[evq[0].bank][evq[0].addr];
                    m_valid = 1;
                    void'(evq.pop_front());
                end
                if (ev) evq.push_back('{cyc + RDL + 1, b, a});
                m_wea = '0;
                m_addr = {NB{AW'(a)}};
                m_rbaddr = AW'(a);
                m_active = 1;
            end else begin
                evq.delete();
                m_valid = 0;
                m_wea = gen_wea;
                m_addr = gen_addr;
                m_active = 0;
            end
            prev_auto = rb_auto;
            prev_bank = rb_bank;
            m_mode = nxt;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_bram_wea",  32'(bram_wea),  32'(m_wea));
            chk("m_bram_addr", 32'(bram_addr), 32'(m_addr));
            chk("m_rb_active", 32'(rb_active), 32'(m_active));
            chk("m_rb_addr",   32'(rb_addr),   32'(m_rbaddr));
            chk("m_rb_valid",  32'(rb_valid),  32'(m_valid));
            chk("m_rb_data",   32'(rb_data),   32'(m_data));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wea"},    32'(bram_wea),  32'd0);
        chk({tag, "_addr"},   32'(bram_addr), 32'd0);
        chk({tag, "_active"}, 32'(rb_active), 32'd0);
        chk({tag, "_rbaddr"}, 32'(rb_addr),   32'd0);
        chk({tag, "_data"},   32'(rb_data),   32'd0);
        chk({tag, "_valid"},  32'(rb_valid),  32'd0);
    endtask

    int pulses;

    initial begin
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < (1 << AW); i++) mem[k][i] = 8'(k * 32 + i);
        mem[1][3] = 8'h5C;

        repeat (2) tick();
        chk_zero("rst");
        rst_n = 1'b1;

        // Pass-through
        gen_wea = 3'b101; gen_addr = {4'hA, 4'h5, 4'h3};
        tick();
        chk("pt_wea",   32'(bram_wea),        32'h5);
        chk("pt_addr2", 32'(bram_addr[11:8]), 32'hA);
        chk("pt_valid", 32'(rb_valid),        32'd0);

        // Drain: writes keep flowing while the generator is busy
        rb_req = 1'b1; gen_busy = 1'b1; rb_bank = 2'd1; sw = 4'h3;
        for (int i = 0; i < 5; i++) begin
            gen_wea = 3'(i + 1); gen_addr = 12'(i * 12'h111);
            tick();
            chk("drain_wea",    32'(bram_wea),  32'(i + 1));
            chk("drain_active", 32'(rb_active), 32'd0);
        end
        gen_busy = 1'b0; gen_wea = 3'b111;
        tick();
        chk("entry_active", 32'(rb_active), 32'd1);
        chk("entry_wea",    32'(bram_wea),  32'd0);

        // Manual read-back
        tick();
        chk("man_early_valid", 32'(rb_valid), 32'd0);
        tick();
        chk("man_valid", 32'(rb_valid), 32'd1);
        chk("man_data",  32'(rb_data),  32'h5C);
        sw = 4'h4;
        tick(); tick();
        chk("sw4_early_valid", 32'(rb_valid), 32'd0);
        tick();
        chk("sw4_valid", 32'(rb_valid), 32'd1);
        chk("sw4_data",  32'(rb_data),  32'h24);
        tick();
        chk("sw4_single_pulse", 32'(rb_valid), 32'd0);
        rb_bank = 2'd3;
        repeat (3) tick();
        chk("bank3_valid", 32'(rb_valid), 32'd1);
        chk("bank3_data",  32'(rb_data),  32'h04);

        // Auto scan over bank 2
        rb_bank = 2'd2; rb_auto = 1'b1; pulses = 0;
        for (int k = 1; k <= 66; k++) begin
            tick();
            if (rb_valid) pulses++;
            if (k == 1)  chk("scan_addr_0",    32'(rb_addr), 32'd0);
            if (k == 3)  chk("scan_data_0",    32'(rb_data), 32'h40);
            if (k == 5)  chk("scan_addr_1",    32'(rb_addr), 32'd1);
            if (k == 61) chk("scan_addr_15",   32'(rb_addr), 32'd15);
            if (k == 65) chk("scan_addr_wrap", 32'(rb_addr), 32'd0);
        end
        chk("scan_pulses", 32'(pulses), 32'd16);

        // Abort right after an address change
        rb_auto = 1'b0; sw = 4'h7;
        tick();
        rb_req = 1'b0; gen_wea = 3'b011;
        tick();
        chk("abort_active", 32'(rb_active), 32'd0);
        chk("abort_wea",    32'(bram_wea),  32'h3);
        chk("abort_valid",  32'(rb_valid),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_valid", 32'(rb_valid), 32'd0);
        end

        // Async reset mid-scan
        rb_req = 1'b1; rb_auto = 1'b1; gen_wea = 3'b111;
        repeat (10) tick();
        chk("pre_rst_addr", 32'(rb_addr), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #1 chk("rst_hold_wea", 32'(bram_wea), 32'd0);
        rb_req = 1'b0; gen_wea = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_wea",    32'(bram_wea),  32'h6);
        chk("post_rst_active", 32'(rb_active), 32'd0);
        rb_req = 1'b1;
        tick();
        chk("reentry_active", 32'(rb_active), 32'd1);
        chk("reentry_addr",   32'(rb_addr),   32'd0);
        tick(); tick();
        chk("reentry_valid", 32'(rb_valid), 32'd1);
        chk("reentry_data",  32'(rb_data),  32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
